// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: four-way round-robin owner of one shared datapath port.
// Produces a registered one-hot grant plus the 2-bit mux select. Ownership
// lasts until the owner completes, withdraws, or has held the port MAX_HOLD cycles.
module mem_port_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned NB_CNT   = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [3:0] o_gnt,
    output logic [1:0] o_sel,
    output logic       o_valid,
    output logic       o_timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // cnt == HOLD_LAST marks the final permitted cycle of a grant
    localparam logic [NB_CNT-1:0] HOLD_LAST = NB_CNT'(MAX_HOLD - 1);

    state_t            state;
    logic [1:0]        ptr;
    logic [NB_CNT-1:0] cnt;

    logic [1:0] winner;
    logic [1:0] idx;
    logic       hit_limit;
    logic       release_now;

    // Pick the first requester at or after ptr, wrapping 3->0. The scan runs
    // from the farthest offset inwards, so the nearest set bit is written last.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(3 - k);
            if (i_req[idx]) begin
                winner = idx;
            end
        end
    end

    // Release conditions for the current owner
    always_comb begin
        hit_limit   = (cnt == HOLD_LAST);
        release_now = i_done || !i_req[o_sel] || hit_limit;
    end

    // Grant FSM with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            o_gnt     <= '0;
            o_sel     <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        state   <= GRANT;
                        o_gnt   <= 4'b0001 << winner;
                        o_sel   <= winner;
                        o_valid <= 1'b1;
                        cnt     <= '0;
                        ptr     <= winner + 2'd1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // done on the last permitted cycle is a normal completion
                        o_timeout <= hit_limit && !i_done;
                        cnt       <= '0;
                        if (|i_req) begin
                            o_gnt   <= 4'b0001 << winner;
                            o_sel   <= winner;
                            o_valid <= 1'b1;
                            ptr     <= winner + 2'd1;
                        end else begin
                            state   <= IDLE;
                            o_gnt   <= '0;
                            o_valid <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + NB_CNT'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
